// File: rtl/rr_mux_stage_if.sv
// Handshake bundle for rr_mux_stage: NUM_CH valid/ready input channels on a flat bus plus one registered output.
// slave is the mux view; master is the requester/downstream view.
interface rr_mux_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 16,
  parameter int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [CW-1:0]                sel_addr;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CW-1:0]                out_ch;

  modport master (
    output in_valid, in_data, sel_addr, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel_addr, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_stage.sv
// N:1 handshaked channel mux (fixed / round-robin / addressed) into one output register; latency 1 cycle.
// Backpressure: while a held beat is not drained, every in_ready is low and the register is frozen.
module rr_mux_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 16,
  parameter int MODE       = 1,
  localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic           clk,
  input logic           rst_n,
  rr_mux_stage_if.slave bus
);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CW-1:0]         out_ch_q;
  logic [CW-1:0]         ptr;

  logic                  grant_vld;
  logic [CW-1:0]         grant;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  load_en;
  logic                  xfer_in;

  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer_in = grant_vld && load_en;

  // Channel tests use a shifted copy of in_valid so the loop index never needs to match CW.
  always_comb begin
    int                idx;
    logic [NUM_CH-1:0] vsh;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    vsh       = '0;
    if (MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        vsh = bus.in_valid >> i;
        if (vsh[0]) begin
          grant_vld = 1'b1;
          grant     = CW'(i);
        end
      end
    end else if (MODE == 1) begin
      // Scan offsets from far to near so the nearest valid channel after ptr is written last.
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(ptr) + k) % NUM_CH;
        vsh = bus.in_valid >> idx;
        if (vsh[0]) begin
          grant_vld = 1'b1;
          grant     = CW'(idx);
        end
      end
    end else begin
      idx = int'(bus.sel_addr);
      vsh = bus.in_valid >> idx;
      if (idx < NUM_CH && vsh[0]) begin
        grant_vld = 1'b1;
        grant     = CW'(idx);
      end
    end
  end

  assign sel_data = DATA_WIDTH'(bus.in_data >> (int'(grant) * DATA_WIDTH));

  // rst_n gating keeps in_ready low for the whole reset window, not just after the first edge.
  assign bus.in_ready = (xfer_in && rst_n) ? (NUM_CH'(1) << grant) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr         <= CW'(NUM_CH - 1);
    end else begin
      if (xfer_in) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_ch_q    <= grant;
        if (MODE == 1) ptr <= grant;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Bench for rr_mux_stage: fixed, round-robin and addressed instances share one stimulus stream
// and are checked every cycle against a behavioural model of the selection rules.
module tb_rr_mux_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  drv_valid = 4'b0;
  logic [63:0] drv_data = 64'h0;
  logic [1:0]  drv_sel = 2'd0;
  logic        drv_rdy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_mux_stage_if #(.DATA_WIDTH(16), .NUM_CH(4)) if_fp ();
  rr_mux_stage_if #(.DATA_WIDTH(16), .NUM_CH(4)) if_rr ();
  rr_mux_stage_if #(.DATA_WIDTH(16), .NUM_CH(4)) if_ad ();

  rr_mux_stage #(.DATA_WIDTH(16), .NUM_CH(4), .MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp.slave));
  rr_mux_stage #(.DATA_WIDTH(16), .NUM_CH(4), .MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  rr_mux_stage #(.DATA_WIDTH(16), .NUM_CH(4), .MODE(2)) u_ad (.clk(clk), .rst_n(rst_n), .bus(if_ad.slave));

  assign if_fp.in_valid = drv_valid;  assign if_rr.in_valid = drv_valid;  assign if_ad.in_valid = drv_valid;
  assign if_fp.in_data  = drv_data;   assign if_rr.in_data  = drv_data;   assign if_ad.in_data  = drv_data;
  assign if_fp.sel_addr = drv_sel;    assign if_rr.sel_addr = drv_sel;    assign if_ad.sel_addr = drv_sel;
  assign if_fp.out_ready = drv_rdy;   assign if_rr.out_ready = drv_rdy;   assign if_ad.out_ready = drv_rdy;

  logic [3:0]  obs_rdy [3];
  logic        obs_vld [3];
  logic [15:0] obs_dat [3];
  logic [1:0]  obs_ch  [3];

  assign obs_rdy[0] = if_fp.in_ready;  assign obs_vld[0] = if_fp.out_valid;
  assign obs_dat[0] = if_fp.out_data;  assign obs_ch[0]  = if_fp.out_ch;
  assign obs_rdy[1] = if_rr.in_ready;  assign obs_vld[1] = if_rr.out_valid;
  assign obs_dat[1] = if_rr.out_data;  assign obs_ch[1]  = if_rr.out_ch;
  assign obs_rdy[2] = if_ad.in_ready;  assign obs_vld[2] = if_ad.out_valid;
  assign obs_dat[2] = if_ad.out_data;  assign obs_ch[2]  = if_ad.out_ch;

  // Reference state per instance (index = MODE): held beat and last round-robin winner.
  logic        m_vld [3];
  logic [15:0] m_dat [3];
  int          m_ch  [3];
  int          m_ptr [3];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s mode%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  function automatic bit has(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int exp_grant(input int mode, input logic [3:0] v, input int ptr, input int sel);
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) if (has(v, i)) return i;
    end else if (mode == 1) begin
      for (int k = 1; k <= 4; k++) if (has(v, (ptr + k) % 4)) return (ptr + k) % 4;
    end else begin
      if (sel < 4 && has(v, sel)) return sel;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_vld[d] = 1'b0;
      m_dat[d] = 16'h0;
      m_ch[d]  = 0;
      m_ptr[d] = 3;
    end
  endtask

  // Check one cycle at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int         g;
    logic [3:0] er;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      g  = exp_grant(d, drv_valid, m_ptr[d], int'(drv_sel));
      er = (g >= 0 && (!m_vld[d] || drv_rdy)) ? 4'(1 << g) : 4'b0;
      chk("in_ready",  d, 32'(obs_rdy[d]), 32'(er));
      chk("out_valid", d, 32'(obs_vld[d]), 32'(m_vld[d]));
      chk("out_data",  d, 32'(obs_dat[d]), 32'(m_dat[d]));
      chk("out_ch",    d, 32'(obs_ch[d]),  32'(m_ch[d]));
      if (er != 4'b0) begin
        m_vld[d] = 1'b1;
        m_dat[d] = 16'(drv_data >> (g * 16));
        m_ch[d]  = g;
        if (d == 1) m_ptr[d] = g;
      end else if (drv_rdy) begin
        m_vld[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] sweep_dat [4];

  initial begin
    sweep_dat[0] = 16'h0A00; sweep_dat[1] = 16'h0B01;
    sweep_dat[2] = 16'h0C02; sweep_dat[3] = 16'h0D03;
    model_reset();

    // Power-on reset, with every channel requesting.
    drv_valid = 4'b1111;
    drv_data  = {16'h0D03, 16'h0C02, 16'h0B01, 16'h0A00};
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", d, 32'(obs_vld[d]), 32'd0);
      chk("rst_in_ready",  d, 32'(obs_rdy[d]), 32'd0);
      chk("rst_out_ch",    d, 32'(obs_ch[d]),  32'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Round-robin sweep at full rate.
    drv_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_sweep_ch",  1, 32'(obs_ch[1]),  32'(k % 4));
      chk("rr_sweep_dat", 1, 32'(obs_dat[1]), 32'(sweep_dat[k % 4]));
      chk("fp_sweep_ch",  0, 32'(obs_ch[0]),  32'd0);
    end

    // Backpressure for three cycles, then release with no bubble.
    drv_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_ch", 1, 32'(obs_ch[1]), 32'd3);
    end
    drv_rdy = 1'b1;
    step();
    chk("bp_release_ch", 1, 32'(obs_ch[1]), 32'd0);

    // Fixed priority: channel 1 shadows channel 3 until it drops.
    drv_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_prio_ch", 0, 32'(obs_ch[0]), 32'd1);
    end
    drv_valid = 4'b1000;
    step();
    chk("fp_drop_ch", 0, 32'(obs_ch[0]), 32'd3);

    // Addressed: hit, then miss on an idle selected channel.
    drv_sel = 2'd2;
    drv_valid = 4'b0100;
    step();
    chk("ad_hit_ch", 2, 32'(obs_ch[2]), 32'd2);
    drv_valid = 4'b1011;
    step();
    step();

    // Sparse round-robin with idle gaps.
    for (int k = 0; k < 10; k++) begin
      drv_valid = (k % 3 == 2) ? 4'b0000 : 4'b1001;
      drv_rdy   = (k % 4 != 3);
      step();
    end

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      drv_valid = 4'($urandom_range(0, 15));
      drv_data  = {$urandom, $urandom};
      drv_sel   = 2'($urandom_range(0, 3));
      drv_rdy   = ($urandom_range(0, 3) != 0);
      step();
    end

    // Mid-stream reset while a beat is held.
    drv_valid = 4'b1111;
    drv_data  = {16'h0D03, 16'h0C02, 16'h0B01, 16'h0A00};
    drv_rdy   = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("mid_rst_out_valid", d, 32'(obs_vld[d]), 32'd0);
      chk("mid_rst_out_data",  d, 32'(obs_dat[d]), 32'd0);
      chk("mid_rst_out_ch",    d, 32'(obs_ch[d]),  32'd0);
      chk("mid_rst_in_ready",  d, 32'(obs_rdy[d]), 32'd0);
    end
    model_reset();
    #1;
    rst_n   = 1'b1;
    drv_rdy = 1'b1;
    step();
    chk("post_rst_rr_ch", 1, 32'(obs_ch[1]), 32'd0);
    step();
    chk("post_rst_rr_ch2", 1, 32'(obs_ch[1]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
